// File: rtl/fu_result_arbiter.sv
// fu_result_arbiter: per-FU result FIFOs drained round-robin onto a registered ROB/CDB broadcast
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-low reset
//   flush              synchronous squash of queued and outgoing results
//   fu_valid/fu_ready  per-FU push handshake; fu_ready depends only on FIFO occupancy
//   fu_robid/flags/wbs/value  packed per-FU result fields, FU i at slice i
//   rob_*              registered ROB broadcast of the granted FIFO head
//   cdb_*              registered CDB broadcast, only for results that write a register
//   pending            some FIFO holds a result or a ROB broadcast is live
module fu_result_arbiter #(
  parameter int FU_COUNT = 8,
  parameter int DEPTH    = 2,
  parameter int ROBID_W  = 4,
  parameter int DATA_W   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [FU_COUNT-1:0]         fu_valid,
  output logic [FU_COUNT-1:0]         fu_ready,
  input  logic [FU_COUNT*ROBID_W-1:0] fu_robid,
  input  logic [FU_COUNT*8-1:0]       fu_flags,
  input  logic [FU_COUNT*8-1:0]       fu_wbs,
  input  logic [FU_COUNT*DATA_W-1:0]  fu_value,
  output logic                        rob_transmit,
  output logic [ROBID_W-1:0]          rob_id,
  output logic [7:0]                  rob_flags,
  output logic [7:0]                  rob_wbs,
  output logic [DATA_W-1:0]           rob_value,
  output logic                        cdb_transmit,
  output logic [3:0]                  cdb_id,
  output logic [DATA_W-1:0]           cdb_val,
  output logic                        pending
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1;

  typedef struct packed {
    logic [ROBID_W-1:0] id;
    logic [7:0]         flags;
    logic [7:0]         wbs;
    logic [DATA_W-1:0]  value;
  } ent_t;

  ent_t          mem_q [FU_COUNT][DEPTH];
  ent_t          mem_d [FU_COUNT][DEPTH];
  logic [AW-1:0] wr_q  [FU_COUNT];
  logic [AW-1:0] wr_d  [FU_COUNT];
  logic [AW-1:0] rd_q  [FU_COUNT];
  logic [AW-1:0] rd_d  [FU_COUNT];
  logic [CW-1:0] cnt_q [FU_COUNT];
  logic [CW-1:0] cnt_d [FU_COUNT];
  logic [PW-1:0] ptr_q, ptr_d;

  logic [FU_COUNT-1:0] push, pop, nonempty;
  logic                gnt_vld, fire;
  logic [PW-1:0]       gnt;
  ent_t                head;

  logic               rob_transmit_q, rob_transmit_d;
  logic [ROBID_W-1:0] rob_id_q, rob_id_d;
  logic [7:0]         rob_flags_q, rob_flags_d;
  logic [7:0]         rob_wbs_q, rob_wbs_d;
  logic [DATA_W-1:0]  rob_value_q, rob_value_d;
  logic               cdb_transmit_q, cdb_transmit_d;
  logic [3:0]         cdb_id_q, cdb_id_d;
  logic [DATA_W-1:0]  cdb_val_q, cdb_val_d;

  // Ready is a pure function of stored occupancy, so a full FIFO stays
  // not-ready even in the cycle it is being popped.
  always_comb begin
    for (int i = 0; i < FU_COUNT; i++) begin
      fu_ready[i] = cnt_q[i] < CW'(DEPTH);
      nonempty[i] = cnt_q[i] != '0;
      push[i]     = fu_valid[i] & fu_ready[i] & ~flush;
    end
  end

  // Round-robin: walking the offsets downwards lets the smallest offset from
  // ptr (the highest-priority requester) be the last, winning, assignment.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = ptr_q;
    for (int k = FU_COUNT - 1; k >= 0; k--) begin
      if (nonempty[PW'((int'(ptr_q) + k) % FU_COUNT)]) begin
        gnt_vld = 1'b1;
        gnt     = PW'((int'(ptr_q) + k) % FU_COUNT);
      end
    end
    fire = gnt_vld & ~flush;
    head = mem_q[gnt][rd_q[gnt]];
    for (int i = 0; i < FU_COUNT; i++)
      pop[i] = fire & (gnt == PW'(i));
  end

  always_comb begin
    for (int i = 0; i < FU_COUNT; i++) begin
      wr_d[i]  = wr_q[i];
      rd_d[i]  = rd_q[i];
      cnt_d[i] = cnt_q[i];
      for (int j = 0; j < DEPTH; j++)
        mem_d[i][j] = mem_q[i][j];
      if (flush) begin
        wr_d[i]  = '0;
        rd_d[i]  = '0;
        cnt_d[i] = '0;
      end else begin
        if (push[i]) begin
          mem_d[i][wr_q[i]] = {fu_robid[i*ROBID_W +: ROBID_W], fu_flags[i*8 +: 8],
                               fu_wbs[i*8 +: 8], fu_value[i*DATA_W +: DATA_W]};
          wr_d[i] = wr_q[i] + 1'b1;
        end
        if (pop[i])
          rd_d[i] = rd_q[i] + 1'b1;
        cnt_d[i] = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
      end
    end
  end

  // Data fields only load on a grant; they are meaningless while transmit is low.
  always_comb begin
    ptr_d          = fire ? ((gnt == PW'(FU_COUNT - 1)) ? '0 : gnt + 1'b1) : ptr_q;
    rob_transmit_d = fire;
    cdb_transmit_d = fire & head.flags[1];
    rob_id_d       = fire ? head.id    : rob_id_q;
    rob_flags_d    = fire ? head.flags : rob_flags_q;
    rob_wbs_d      = fire ? head.wbs   : rob_wbs_q;
    rob_value_d    = fire ? head.value : rob_value_q;
    cdb_id_d       = fire ? head.wbs[3:0] : cdb_id_q;
    cdb_val_d      = fire ? head.value : cdb_val_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q          <= '{default: '0};
      wr_q           <= '{default: '0};
      rd_q           <= '{default: '0};
      ptr_q          <= '0;
      rob_transmit_q <= 1'b0;
      rob_id_q       <= '0;
      rob_flags_q    <= '0;
      rob_wbs_q      <= '0;
      rob_value_q    <= '0;
      cdb_transmit_q <= 1'b0;
      cdb_id_q       <= '0;
      cdb_val_q      <= '0;
    end else begin
      cnt_q          <= cnt_d;
      wr_q           <= wr_d;
      rd_q           <= rd_d;
      ptr_q          <= ptr_d;
      rob_transmit_q <= rob_transmit_d;
      rob_id_q       <= rob_id_d;
      rob_flags_q    <= rob_flags_d;
      rob_wbs_q      <= rob_wbs_d;
      rob_value_q    <= rob_value_d;
      cdb_transmit_q <= cdb_transmit_d;
      cdb_id_q       <= cdb_id_d;
      cdb_val_q      <= cdb_val_d;
    end
  end

  // Entry storage is qualified by counts/pointers, so it needs no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rob_transmit = rob_transmit_q;
  assign rob_id       = rob_id_q;
  assign rob_flags    = rob_flags_q;
  assign rob_wbs      = rob_wbs_q;
  assign rob_value    = rob_value_q;
  assign cdb_transmit = cdb_transmit_q;
  assign cdb_id       = cdb_id_q;
  assign cdb_val      = cdb_val_q;
  assign pending      = (|nonempty) | rob_transmit_q;
endmodule

// File: tb/tb_fu_result_arbiter.sv
// tb_fu_result_arbiter: queue-model scoreboard plus directed literal checks for fu_result_arbiter
module tb_fu_result_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic [7:0]  fu_valid = '0;
  logic [7:0]  fu_ready;
  logic [31:0] fu_robid = '0;
  logic [63:0] fu_flags = '0;
  logic [63:0] fu_wbs = '0;
  logic [63:0] fu_value = '0;
  logic        rob_transmit;
  logic [3:0]  rob_id;
  logic [7:0]  rob_flags, rob_wbs, rob_value;
  logic        cdb_transmit;
  logic [3:0]  cdb_id;
  logic [7:0]  cdb_val;
  logic        pending;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fu_result_arbiter dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fu_valid(fu_valid), .fu_ready(fu_ready),
    .fu_robid(fu_robid), .fu_flags(fu_flags), .fu_wbs(fu_wbs), .fu_value(fu_value),
    .rob_transmit(rob_transmit), .rob_id(rob_id), .rob_flags(rob_flags),
    .rob_wbs(rob_wbs), .rob_value(rob_value),
    .cdb_transmit(cdb_transmit), .cdb_id(cdb_id), .cdb_val(cdb_val),
    .pending(pending)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic put(input int i, input logic [3:0] id, input logic [7:0] fl,
                     input logic [7:0] wb, input logic [7:0] v);
    fu_valid[i]        = 1'b1;
    fu_robid[i*4 +: 4] = id;
    fu_flags[i*8 +: 8] = fl;
    fu_wbs[i*8 +: 8]   = wb;
    fu_value[i*8 +: 8] = v;
  endtask

  task automatic idle();
    fu_valid = '0;
  endtask

  typedef struct packed {
    logic [3:0] id;
    logic [7:0] fl;
    logic [7:0] wb;
    logic [7:0] v;
  } ent_t;

  ent_t       mq [8][$];
  int         m_ptr = 0;
  int         mg;
  bit         e_rt = 0;
  bit         e_ct = 0;
  ent_t       e_h = '0;
  logic [7:0] mrdy;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) mq[i].delete();
      m_ptr = 0;
      e_rt  = 0;
      e_ct  = 0;
    end else begin
      for (int i = 0; i < 8; i++) mrdy[i] = mq[i].size() < 2;
      mg = -1;
      if (!flush)
        for (int k = 0; k < 8; k++)
          if (mg < 0 && mq[(m_ptr + k) % 8].size() > 0) mg = (m_ptr + k) % 8;
      e_rt = mg >= 0;
      e_ct = 0;
      if (mg >= 0) begin
        e_h   = mq[mg].pop_front();
        e_ct  = e_h.fl[1];
        m_ptr = (mg + 1) % 8;
      end
      if (flush)
        for (int i = 0; i < 8; i++) mq[i].delete();
      else
        for (int i = 0; i < 8; i++)
          if (fu_valid[i] && mrdy[i])
            mq[i].push_back({fu_robid[i*4 +: 4], fu_flags[i*8 +: 8], fu_wbs[i*8 +: 8], fu_value[i*8 +: 8]});
    end
  end

  logic [3:0] seen [$];
  logic [7:0] c_rdy;
  bit         c_pend;

  always @(negedge clk) begin
    if (rst) begin
      c_pend = e_rt;
      for (int i = 0; i < 8; i++) begin
        c_rdy[i] = mq[i].size() < 2;
        if (mq[i].size() > 0) c_pend = 1;
      end
      chk("m_rob_transmit", rob_transmit, e_rt);
      chk("m_cdb_transmit", cdb_transmit, e_ct);
      chk("m_fu_ready", fu_ready, c_rdy);
      chk("m_pending", pending, c_pend);
      if (e_rt) begin
        chk("m_rob_id", rob_id, e_h.id);
        chk("m_rob_flags", rob_flags, e_h.fl);
        chk("m_rob_wbs", rob_wbs, e_h.wb);
        chk("m_rob_value", rob_value, e_h.v);
      end
      if (e_ct) begin
        chk("m_cdb_id", cdb_id, e_h.wb[3:0]);
        chk("m_cdb_val", cdb_val, e_h.v);
      end
      if (rob_transmit) seen.push_back(rob_id);
    end
  end

  logic [3:0] exp4 [6] = '{4'd1, 4'd2, 4'd3, 4'd10, 4'd11, 4'd12};

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", fu_ready, 8'hFF);
    chk("rst_pending", pending, 0);
    chk("rst_rob_tx", rob_transmit, 0);
    chk("rst_rob_id", rob_id, 0);
    chk("rst_cdb_val", cdb_val, 0);
    rst = 1'b1;

    @(negedge clk);
    for (int i = 0; i < 8; i++) put(i, 4'(i), 8'h02, {4'h0, 4'(i)}, 8'(16 * i + 1));
    @(negedge clk);
    idle();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("order_tx", rob_transmit, 1);
      chk("order_id", rob_id, k);
    end
    @(negedge clk);
    chk("order_pending", pending, 0);
    chk("order_model_ptr", m_ptr, 0);

    seen.delete();
    put(0, 4'd1, 8'h02, 8'h01, 8'hA1);
    put(1, 4'd2, 8'h02, 8'h02, 8'hA2);
    put(2, 4'd3, 8'h02, 8'h03, 8'hA3);
    put(3, 4'd10, 8'h02, 8'h03, 8'hB0);
    @(negedge clk);
    idle();
    put(3, 4'd11, 8'h02, 8'h13, 8'hB1);
    @(negedge clk);
    chk("full_ready_e1", fu_ready[3], 0);
    put(3, 4'd12, 8'h02, 8'h23, 8'hB2);
    @(negedge clk);
    chk("full_ready_e2", fu_ready[3], 0);
    @(negedge clk);
    chk("full_ready_e3", fu_ready[3], 0);
    @(negedge clk);
    chk("full_ready_e4", fu_ready[3], 1);
    @(negedge clk);
    idle();
    repeat (4) @(negedge clk);
    chk("hold_count", seen.size(), 6);
    for (int j = 0; j < 6 && j < seen.size(); j++) chk("hold_seq", seen[j], exp4[j]);

    put(2, 4'd5, 8'h02, 8'h3A, 8'h77);
    @(negedge clk);
    idle();
    @(negedge clk);
    chk("single_rob_tx", rob_transmit, 1);
    chk("single_rob_id", rob_id, 5);
    chk("single_rob_wbs", rob_wbs, 8'h3A);
    chk("single_cdb_tx", cdb_transmit, 1);
    chk("single_cdb_id", cdb_id, 4'hA);
    chk("single_cdb_val", cdb_val, 8'h77);
    @(negedge clk);
    chk("single_pulse_rob", rob_transmit, 0);
    chk("single_pulse_cdb", cdb_transmit, 0);

    put(6, 4'd7, 8'h01, 8'h5B, 8'h33);
    @(negedge clk);
    idle();
    @(negedge clk);
    chk("nowr_rob_tx", rob_transmit, 1);
    chk("nowr_rob_id", rob_id, 7);
    chk("nowr_rob_flags", rob_flags, 8'h01);
    chk("nowr_cdb_tx", cdb_transmit, 0);
    @(negedge clk);

    seen.delete();
    for (int i = 0; i < 6; i++) put(i, 4'(8 + i), 8'h02, {4'h0, 4'(i)}, 8'(32 + i));
    @(negedge clk);
    idle();
    @(negedge clk);
    chk("flush_live_tx", rob_transmit, 1);
    chk("flush_live_id", rob_id, 8);
    flush = 1'b1;
    put(6, 4'd15, 8'h02, 8'h0F, 8'hEE);
    @(negedge clk);
    flush = 1'b0;
    idle();
    chk("flush_rob_tx", rob_transmit, 0);
    chk("flush_cdb_tx", cdb_transmit, 0);
    chk("flush_pending", pending, 0);
    chk("flush_ready", fu_ready, 8'hFF);
    repeat (6) @(negedge clk);
    chk("flush_seen_count", seen.size(), 1);
    if (seen.size() > 0) chk("flush_seen_id", seen[0], 8);

    put(4, 4'd1, 8'h02, 8'h01, 8'h11);
    put(5, 4'd2, 8'h02, 8'h02, 8'h22);
    put(6, 4'd3, 8'h02, 8'h03, 8'h33);
    @(negedge clk);
    idle();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_ready", fu_ready, 8'hFF);
    chk("arst_rob_tx", rob_transmit, 0);
    chk("arst_cdb_tx", cdb_transmit, 0);
    chk("arst_pending", pending, 0);
    chk("arst_rob_id", rob_id, 0);
    chk("arst_rob_value", rob_value, 0);
    chk("arst_cdb_id", cdb_id, 0);
    chk("arst_cdb_val", cdb_val, 0);
    @(negedge clk);
    #1;
    chk("arst_hold_pending", pending, 0);
    rst = 1'b1;
    put(7, 4'd9, 8'h02, 8'h07, 8'h99);
    put(0, 4'd6, 8'h02, 8'h06, 8'h66);
    @(negedge clk);
    idle();
    @(negedge clk);
    chk("arst_ptr_first", rob_id, 6);
    @(negedge clk);
    chk("arst_ptr_second", rob_id, 9);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fu_result_arbiter.md
# fu_result_arbiter

Collects completed results from up to FU_COUNT functional units and sends them to the ROB and the CDB, at most one result per cycle. Each FU gets a small private FIFO and a valid/ready handshake, so an FU that cannot transmit is held back instead of sharing a wired-OR result bus. It sits between the FU array and the ROB/PRF, replacing the daisy-chained transmit/OR combine. It drives the registered rob_* / cdb_* broadcast signals.

## Interface
- FU_COUNT, 8, number of FU result ports
- DEPTH, 2, entries per FU FIFO; power of two, ≥2
- ROBID_W, 4, ROB id width
- DATA_W, 8, result value width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- flush  in  1  synchronous squash of all queued and outgoing results (branch mispredict)
- fu_valid  in  FU_COUNT  FU i presents a result
- fu_ready  out  FU_COUNT  FIFO i can accept
- fu_robid  in  FU_COUNT×ROBID_W  ROB id per FU, packed, FU i at [i*ROBID_W +: ROBID_W]
- fu_flags  in  FU_COUNT×8  instruction flags; bit1 = writes register
- fu_wbs  in  FU_COUNT×8  [3:0] new phys reg, [7:4] old phys reg
- fu_value  in  FU_COUNT×DATA_W  result value
- rob_transmit  out  1  ROB broadcast valid
- rob_id  out  ROBID_W  ROB id of broadcast
- rob_flags  out  8  flags of broadcast
- rob_wbs  out  8  wbs of broadcast
- rob_value  out  DATA_W  value of broadcast
- cdb_transmit  out  1  CDB broadcast valid
- cdb_id  out  4  phys reg being produced
- cdb_val  out  DATA_W  value on CDB
- pending  out  1  any FIFO non-empty or rob_transmit high

## Operation
- Push: at a rising edge where fu_valid[i] & fu_ready[i] & !flush, the tuple {robid, flags, wbs, value} is written into FIFO i.
- fu_ready[i] = (count[i] < DEPTH). It depends only on registered state. It does not depend on fu_valid or on a pop in the same cycle, so a full FIFO stays not-ready during its pop cycle.
- Arbitration is round-robin over non-empty FIFOs, using priority pointer ptr (0..FU_COUNT-1).
  - The search starts at ptr and wraps modulo FU_COUNT.
  - The granted FIFO g is popped at the edge.
  - ptr ← (g+1) mod FU_COUNT on a grant; ptr is unchanged when there is no grant.
- Output registers load at every edge:
  - rob_transmit ← grant valid; rob_* ← head of FIFO g.
  - cdb_transmit ← grant valid & head.flags[1]; cdb_id ← head.wbs[3:0]; cdb_val ← head.value.
  - With no grant, both transmit bits go 0. The data fields hold their last value; they are don't-care while transmit is 0.
- FIFO i can push and pop in the same cycle; its count is then unchanged.
- Counts are ($clog2(DEPTH)+1) bits. Read and write pointers are $clog2(DEPTH) bits and wrap naturally.
- flush (synchronous, highest priority):
  - all counts and FIFO pointers → 0;
  - rob_transmit and cdb_transmit → 0 at that edge;
  - same-cycle pushes are dropped and there is no pop;
  - ptr is unchanged.
- Reset (rst=0, asynchronous), regardless of any operation in progress:
  - all counts, FIFO pointers, ptr, rob_transmit, cdb_transmit and pending → 0;
  - rob_id, rob_flags, rob_wbs, rob_value, cdb_id, cdb_val → 0;
  - fu_ready → all 1s immediately (combinational from counts).

## Timing
- Latency: a result accepted at edge N into an otherwise empty arbiter with ptr favourable is broadcast during the cycle after edge N+1. That is 2 edges; there is no bypass path.
- Throughput: 1 broadcast per cycle in aggregate; each FU sustains 1 per cycle when it is the only requester.
- Fairness: with K FIFOs continuously non-empty, each is granted once every K cycles.
- Worst-case wait for FIFO i head: FU_COUNT-1 cycles.
- Every broadcast is a single-cycle pulse per result. There are no duplicates and no losses unless flush is asserted.
- pending is combinational from registered state.

## Test plan
- Reset: hold rst=0 mid-traffic, then release → rob_transmit=cdb_transmit=0, fu_ready=8'hFF, pending=0, ptr=0.
- Single FU 2 pushes a result (robid=5, flags=8'h02, wbs=8'h3A, value=8'h77) at edge N → rob_transmit=1, rob_id=5, cdb_transmit=1, cdb_id=4'hA, cdb_val=8'h77 after edge N+1, for exactly one cycle.
- All 8 FUs push one result in the same cycle with ptr=0 → broadcasts in FU order 0,1,…,7 on 8 consecutive cycles. Then ptr=0 again and pending=0.
- FU 3 pushes 3 results back-to-back while no pops occur (another FU is granted, DEPTH=2) → fu_ready[3]=0 after 2 accepts. The third result is held until a pop, and no result is lost.
- A result with flags bit1=0 → rob_transmit=1 and cdb_transmit=0.
- Flush with 5 queued results and a live broadcast → both transmits are 0 the next cycle, pending=0, and the dropped robids never appear.
